// File: rtl/adc_cap_pkg.sv
// Shared types and default sizing for the ADC capture buffer.
package adc_cap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_CAPTURE,
        ST_DRAIN
    } state_t;

    localparam int DEF_DATA_W = 12;
    localparam int DEF_DEPTH  = 1024;

endpackage

// File: rtl/adc_cap_ram.sv
// Simple dual-port capture RAM: one write port, one registered read port.
module adc_cap_ram
    import adc_cap_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) r_q <= r_mem[i_raddr];
    end

    assign o_rdata = r_q;

endmodule

// File: rtl/adc_capture_buffer.sv
// Trigger-qualified ADC capture: arm, capture len samples on a trigger
// edge, then drain them oldest-first through a 2-entry output skid.
module adc_capture_buffer
    import adc_cap_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int CNT_W  = $clog2(DEF_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arm,
    input  logic              abort,
    input  logic [CNT_W-1:0]  cap_len,
    input  logic              trig_in,
    input  logic              adc_valid,
    input  logic [DATA_W-1:0] adc_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done,
    output logic              cap_err
);

    localparam int               PTR_W   = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_t            r_state, w_next;
    logic              r_trig_q;
    logic [CNT_W-1:0]  r_len, r_wr_cnt, r_rd_cnt, r_tx_cnt;
    logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
    logic              r_rd_pend;
    logic [1:0]        r_sk_cnt;
    logic [DATA_W-1:0] r_sk0, r_sk1;
    logic              r_done, r_cap_err;

    logic [DATA_W-1:0] w_rdata;
    logic              w_trig_rise, w_arm_ok, w_arm_bad;
    logic              w_we, w_re, w_pop;
    logic              w_last_wr, w_last_tx;
    logic [1:0]        w_occ;

    assign w_trig_rise = trig_in & ~r_trig_q;
    assign w_pop       = out_valid & out_ready;
    assign w_last_wr   = w_we & (r_wr_cnt == r_len - ONE);
    assign w_last_tx   = w_pop & (r_tx_cnt == r_len - ONE);
    // Skid slots committed after this cycle: held + in-flight read - leaving.
    assign w_occ = r_sk_cnt - 2'(w_pop) + 2'(r_rd_pend);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (abort) begin
            w_next = ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE:    if (w_arm_ok) w_next = ST_ARMED;
                ST_ARMED:   if (w_trig_rise)
                                w_next = w_last_wr ? ST_DRAIN : ST_CAPTURE;
                ST_CAPTURE: if (w_last_wr) w_next = ST_DRAIN;
                ST_DRAIN:   if (w_last_tx) w_next = ST_IDLE;
                default:    w_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy      = (r_state != ST_IDLE);
        w_arm_ok  = 1'b0;
        w_arm_bad = 1'b0;
        w_we      = 1'b0;
        w_re      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_arm_ok  = arm & ~abort & (cap_len != '0);
                w_arm_bad = arm & ~abort & (cap_len == '0);
            end
            ST_ARMED:   w_we = adc_valid & w_trig_rise & ~abort;
            ST_CAPTURE: w_we = adc_valid & ~abort;
            ST_DRAIN:   w_re = ~abort & (r_rd_cnt != r_len) & (w_occ < 2'd2);
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_trig_q  <= 1'b0;
            r_cap_err <= 1'b0;
            r_done    <= 1'b0;
            r_rd_pend <= 1'b0;
            r_len     <= '0;
            r_wr_ptr  <= '0;
            r_wr_cnt  <= '0;
            r_rd_ptr  <= '0;
            r_rd_cnt  <= '0;
            r_tx_cnt  <= '0;
            r_sk_cnt  <= '0;
            r_sk0     <= '0;
            r_sk1     <= '0;
        end else begin
            r_trig_q  <= trig_in;
            r_cap_err <= w_arm_bad;
            r_done    <= w_last_tx & ~abort;
            r_rd_pend <= w_re;
            if (w_arm_ok)
                r_len <= (cap_len > LEN_MAX) ? LEN_MAX : cap_len;
            if (abort || w_arm_ok) begin
                r_wr_ptr <= '0;
                r_wr_cnt <= '0;
                r_rd_ptr <= '0;
                r_rd_cnt <= '0;
                r_tx_cnt <= '0;
                r_sk_cnt <= '0;
            end else begin
                if (w_we) begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                    r_wr_cnt <= r_wr_cnt + ONE;
                end
                if (w_re) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                    r_rd_cnt <= r_rd_cnt + ONE;
                end
                if (w_pop) r_tx_cnt <= r_tx_cnt + ONE;
                unique case ({r_rd_pend, w_pop})
                    2'b10: begin
                        if (r_sk_cnt == 2'd0) r_sk0 <= w_rdata;
                        else                  r_sk1 <= w_rdata;
                        r_sk_cnt <= r_sk_cnt + 2'd1;
                    end
                    2'b01: begin
                        r_sk0    <= r_sk1;
                        r_sk_cnt <= r_sk_cnt - 2'd1;
                    end
                    2'b11: begin
                        if (r_sk_cnt == 2'd1) begin
                            r_sk0 <= w_rdata;
                        end else begin
                            r_sk0 <= r_sk1;
                            r_sk1 <= w_rdata;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    adc_cap_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (PTR_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (adc_data),
        .i_re    (w_re),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    assign out_valid = (r_sk_cnt != 2'd0);
    assign out_data  = r_sk0;
    assign done      = r_done;
    assign cap_err   = r_cap_err;

endmodule

// File: tb/tb_adc_capture_buffer.sv
// Self-checking bench for adc_capture_buffer: vector table, random
// gaps/back-pressure against a queue model, and corner sequences.
module tb_adc_capture_buffer;

    logic        clk = 1'b0;
    logic        rst, arm, abort, trig_in, adc_valid, out_ready;
    logic [10:0] cap_len;
    logic [11:0] adc_data;
    logic        out_valid, busy, done, cap_err;
    logic [11:0] out_data;

    int checks   = 0;
    int failures = 0;

    logic [11:0] exp_q[$];
    logic [11:0] got_q[$];

    typedef struct {
        int          len;
        int          mode;
        int          rdy;
        int          exp_n;
        logic [11:0] base;
    } vec_t;

    vec_t tbl[8];

    adc_capture_buffer dut (
        .clk       (clk),
        .rst       (rst),
        .arm       (arm),
        .abort     (abort),
        .cap_len   (cap_len),
        .trig_in   (trig_in),
        .adc_valid (adc_valid),
        .adc_data  (adc_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done),
        .cap_err   (cap_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_idle_outs(input string nm);
        chk({nm, "_busy"}, 32'(busy), 0);
        chk({nm, "_ovalid"}, 32'(out_valid), 0);
        chk({nm, "_odata"}, 32'(out_data), 0);
        chk({nm, "_done"}, 32'(done), 0);
        chk({nm, "_caperr"}, 32'(cap_err), 0);
    endtask

    // Arm, trigger, and present a sample stream; the model keeps the
    // first exp_n valid samples from the trigger cycle onward.
    task automatic capture(input vec_t v);
        int          nv;
        int          k;
        logic [11:0] d;
        exp_q.delete();
        out_ready = 1'b0;
        trig_in   = 1'b0;
        adc_valid = 1'b0;
        cap_len   = 11'(v.len);
        arm       = 1'b1;
        step();
        arm     = 1'b0;
        cap_len = '0;
        chk("busy_armed", 32'(busy), 1);
        trig_in = 1'b1;
        nv = 0;
        k  = 0;
        while (nv < v.exp_n + 3) begin
            case (v.mode)
                0:       adc_valid = 1'b1;
                1:       adc_valid = (k % 2 == 0);
                default: adc_valid = 1'($urandom_range(0, 1));
            endcase
            d = (v.mode == 0) ? v.base + 12'(nv) : 12'($urandom);
            adc_data = d;
            if (adc_valid) begin
                if (nv < v.exp_n) exp_q.push_back(d);
                nv++;
            end
            k++;
            step();
        end
        adc_valid = 1'b0;
        trig_in   = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int          cyc;
        int          first_t;
        int          last_t;
        int          ndone;
        logic        hold;
        logic [11:0] prev_d;
        capture(v);
        got_q.delete();
        cyc     = 0;
        first_t = -1;
        last_t  = -1;
        ndone   = 0;
        hold    = 1'b0;
        prev_d  = '0;
        while (got_q.size() < v.exp_n && cyc < 20000) begin
            if (hold) begin
                chk("hold_valid", 32'(out_valid), 1);
                chk("hold_data", 32'(out_data), 32'(prev_d));
            end
            if (done) ndone++;
            out_ready = ($urandom_range(0, 99) < v.rdy);
            if (out_valid && out_ready) begin
                got_q.push_back(out_data);
                if (first_t < 0) first_t = cyc;
                last_t = cyc;
            end
            hold   = out_valid && !out_ready;
            prev_d = out_data;
            step();
            cyc++;
        end
        out_ready = 1'b0;
        chk("n_out", 32'(got_q.size()), 32'(v.exp_n));
        chk("done_early", 32'(ndone), 0);
        chk("done_pulse", 32'(done), 1);
        chk("busy_end", 32'(busy), 0);
        if (v.rdy == 100)
            chk("burst_len", 32'(last_t - first_t), 32'(v.exp_n - 1));
        for (int i = 0; i < got_q.size() && i < v.exp_n; i++)
            chk("sample", 32'(got_q[i]), 32'(exp_q[i]));
        step();
        chk("done_clear", 32'(done), 0);
        chk("ovalid_end", 32'(out_valid), 0);
    endtask

    initial begin
        int   got;
        int   cyc;
        int   rl;
        vec_t rv;

        tbl[0] = '{len: 8,    mode: 0, rdy: 100, exp_n: 8,    base: 12'h000};
        tbl[1] = '{len: 3,    mode: 0, rdy: 100, exp_n: 3,    base: 12'h5A5};
        tbl[2] = '{len: 1,    mode: 0, rdy: 100, exp_n: 1,    base: 12'h123};
        tbl[3] = '{len: 12,   mode: 1, rdy: 50,  exp_n: 12,   base: 12'h000};
        tbl[4] = '{len: 20,   mode: 2, rdy: 50,  exp_n: 20,   base: 12'h000};
        tbl[5] = '{len: 2000, mode: 0, rdy: 100, exp_n: 1024, base: 12'h000};
        tbl[6] = '{len: 1024, mode: 1, rdy: 70,  exp_n: 1024, base: 12'h000};
        tbl[7] = '{len: 7,    mode: 2, rdy: 30,  exp_n: 7,    base: 12'h000};

        rst       = 1'b1;
        arm       = 1'b0;
        abort     = 1'b0;
        trig_in   = 1'b0;
        adc_valid = 1'b0;
        out_ready = 1'b0;
        cap_len   = '0;
        adc_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_idle_outs("reset");
        @(negedge clk);
        rst = 1'b0;
        step();

        for (int i = 0; i < 8; i++) run_vec(tbl[i]);

        for (int i = 0; i < 4; i++) begin
            rl = $urandom_range(1, 40);
            rv = '{len: rl, mode: 2, rdy: 40 + 15 * i,
                   exp_n: (rl > 1024) ? 1024 : rl, base: 12'h000};
            run_vec(rv);
        end

        cap_len = '0;
        arm     = 1'b1;
        step();
        arm = 1'b0;
        chk("zero_caperr", 32'(cap_err), 1);
        chk("zero_busy", 32'(busy), 0);
        step();
        chk("zero_caperr_clr", 32'(cap_err), 0);
        chk("zero_busy2", 32'(busy), 0);

        cap_len = 11'd5;
        arm     = 1'b1;
        abort   = 1'b1;
        step();
        arm   = 1'b0;
        abort = 1'b0;
        chk("arm_abort_busy", 32'(busy), 0);

        trig_in = 1'b1;
        step();
        step();
        cap_len = 11'd4;
        arm     = 1'b1;
        step();
        arm       = 1'b0;
        adc_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            adc_data = 12'(i);
            step();
        end
        chk("trig_hi_busy", 32'(busy), 1);
        chk("trig_hi_ovalid", 32'(out_valid), 0);
        adc_valid = 1'b0;
        abort     = 1'b1;
        step();
        abort   = 1'b0;
        trig_in = 1'b0;
        chk("trig_hi_abort", 32'(busy), 0);
        step();

        capture('{len: 8, mode: 0, rdy: 100, exp_n: 8, base: 12'h100});
        out_ready = 1'b1;
        got = 0;
        cyc = 0;
        while (got < 3 && cyc < 50) begin
            if (out_valid) begin
                chk("abort_pre", 32'(out_data), 32'(exp_q[got]));
                got++;
            end
            step();
            cyc++;
        end
        chk("abort_pre_n", 32'(got), 3);
        out_ready = 1'b0;
        abort     = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_ovalid", 32'(out_valid), 0);
        chk("abort_busy", 32'(busy), 0);
        for (int i = 0; i < 5; i++) begin
            chk("abort_nodone", 32'(done), 0);
            step();
        end
        run_vec(tbl[3]);

        cap_len = 11'd16;
        arm     = 1'b1;
        step();
        arm       = 1'b0;
        trig_in   = 1'b1;
        adc_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            adc_data = 12'($urandom);
            step();
        end
        chk("prerst_busy", 32'(busy), 1);
        #3;
        rst = 1'b1;
        #1;
        chk_idle_outs("async_rst");
        adc_valid = 1'b0;
        trig_in   = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("post_rst_busy", 32'(busy), 0);
        run_vec(tbl[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
